// File: rtl/parking_pkg.sv
// Shared types and constants for the parking occupancy tracker.
package parking_pkg;

    localparam int unsigned CNT_W            = 4;
    localparam int unsigned DEFAULT_CAPACITY = 8;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage : parking_pkg

// File: rtl/parking_management_system_if.sv
// Sensor inputs and occupancy outputs of the parking tracker, grouped as one bundle.
interface parking_management_system_if;
    import parking_pkg::*;

    logic ENTRY_sensor;
    logic EXIT_sensor;
    cnt_t Parking_count;
    cnt_t Available_spots;
    logic FULL;
    logic EMPTY;

    // master: sensor conditioning / bench side; slave: the tracker itself
    modport master (
        output ENTRY_sensor, EXIT_sensor,
        input  Parking_count, Available_spots, FULL, EMPTY
    );

    modport slave (
        input  ENTRY_sensor, EXIT_sensor,
        output Parking_count, Available_spots, FULL, EMPTY
    );

endinterface : parking_management_system_if

// File: rtl/parking_management_system_sensor_edge_detect.sv
// Rising-edge detector: a 1-cycle pulse in the same cycle the level is first seen high.
module sensor_edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic level_in,
    output logic pulse_o
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level_in;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Combinational so the counter reacts on the edge that first samples the level high.
    assign pulse_o = level_in & ~prev_q;

endmodule : sensor_edge_detect

// File: rtl/parking_management_system.sv
// Occupancy tracker: counts entry/exit events with saturation at 0 and CAPACITY.
module parking_management_system
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY = DEFAULT_CAPACITY
) (
    input  logic                         CLK,
    input  logic                         RESET,
    parking_management_system_if.slave   bus
);

    localparam cnt_t CAP = cnt_t'(CAPACITY);

    logic ent_pulse;
    logic ext_pulse;
    cnt_t count_q;
    cnt_t count_d;

    sensor_edge_detect u_entry_edge (
        .CLK      (CLK),
        .RESET    (RESET),
        .level_in (bus.ENTRY_sensor),
        .pulse_o  (ent_pulse)
    );

    sensor_edge_detect u_exit_edge (
        .CLK      (CLK),
        .RESET    (RESET),
        .level_in (bus.EXIT_sensor),
        .pulse_o  (ext_pulse)
    );

    // Simultaneous in and out cancel, so only a lone event can move the count.
    always_comb begin
        count_d = count_q;
        if (ent_pulse && !ext_pulse && (count_q < CAP)) begin
            count_d = count_q + cnt_t'(1);
        end else if (ext_pulse && !ent_pulse && (count_q != '0)) begin
            count_d = count_q - cnt_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Derived outputs follow the count directly, so they never lag it.
    assign bus.Parking_count   = count_q;
    assign bus.Available_spots = CAP - count_q;
    assign bus.FULL            = (count_q == CAP);
    assign bus.EMPTY           = (count_q == '0);

endmodule : parking_management_system

// File: tb/tb_parking_management_system.sv
// Self-checking bench: vector table, hand-written reset sequences and randomized traffic vs. a model.
module tb_parking_management_system;
    import parking_pkg::*;

    localparam int CAP = 8;

    logic CLK;
    logic RESET;

    parking_management_system_if bus ();

    parking_management_system #(.CAPACITY(CAP)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit e;
        bit x;
        int exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model: occupancy plus the last sensor levels it has seen
    int m_cnt = 0;
    bit m_pe  = 0;
    bit m_px  = 0;

    function automatic void model_reset();
        m_cnt = 0;
        m_pe  = 0;
        m_px  = 0;
    endfunction

    function automatic void model_step(bit e, bit x);
        bit car_in;
        bit car_out;
        car_in  = e && !m_pe;
        car_out = x && !m_px;
        m_pe = e;
        m_px = x;
        if (car_in && !car_out && m_cnt < CAP)      m_cnt = m_cnt + 1;
        else if (car_out && !car_in && m_cnt > 0)   m_cnt = m_cnt - 1;
    endfunction

    task automatic cmp(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_all(string tag, int exp_cnt);
        cmp({tag, " count"}, int'(bus.Parking_count), exp_cnt);
        cmp({tag, " avail"}, int'(bus.Available_spots), CAP - exp_cnt);
        cmp({tag, " full"},  int'(bus.FULL),  (exp_cnt == CAP) ? 1 : 0);
        cmp({tag, " empty"}, int'(bus.EMPTY), (exp_cnt == 0) ? 1 : 0);
    endtask

    // drive at the falling edge, sample 1 time unit after the rising edge
    task automatic apply(bit e, bit x);
        @(negedge CLK);
        bus.ENTRY_sensor = e;
        bus.EXIT_sensor  = x;
        @(posedge CLK);
        #1;
        model_step(e, x);
    endtask

    function automatic void add(bit e, bit x, int exp);
        vec_t v;
        v.e = e; v.x = x; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        RESET            = 1'b0;
        bus.ENTRY_sensor = 1'b0;
        bus.EXIT_sensor  = 1'b0;

        // five pulses in, two out
        for (int i = 1; i <= 5; i++) begin add(1, 0, i); add(0, 0, i); end
        for (int i = 4; i >= 3; i--) begin add(0, 1, i); add(0, 0, i); end
        // fill to capacity, then one more entry is refused
        for (int i = 4; i <= 8; i++) begin add(1, 0, i); add(0, 0, i); end
        add(1, 0, 8); add(0, 0, 8);
        // drain past empty, no wrap
        for (int i = 7; i >= 0; i--) begin add(0, 1, i); add(0, 0, i); end
        for (int i = 0; i < 3; i++)  begin add(0, 1, 0); add(0, 0, 0); end
        // entry held high for 10 cycles counts once
        for (int i = 0; i < 10; i++) add(1, 0, 1);
        add(0, 0, 1);
        for (int i = 2; i <= 4; i++) begin add(1, 0, i); add(0, 0, i); end
        // simultaneous in/out at 4, 8 and 0
        add(1, 1, 4); add(0, 0, 4);
        for (int i = 5; i <= 8; i++) begin add(1, 0, i); add(0, 0, i); end
        add(1, 1, 8); add(0, 0, 8);
        for (int i = 7; i >= 0; i--) begin add(0, 1, i); add(0, 0, i); end
        add(1, 1, 0); add(0, 0, 0);

        // reset held for two edges
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        check_all("reset", 0);

        @(negedge CLK);
        RESET = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].e, vecs[i].x);
            cmp($sformatf("vec%0d count", i), int'(bus.Parking_count), vecs[i].exp);
            cmp($sformatf("vec%0d avail", i), int'(bus.Available_spots), CAP - vecs[i].exp);
            cmp($sformatf("vec%0d full", i),  int'(bus.FULL),  (vecs[i].exp == CAP) ? 1 : 0);
            cmp($sformatf("vec%0d empty", i), int'(bus.EMPTY), (vecs[i].exp == 0) ? 1 : 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit e;
            bit x;
            e = ($urandom_range(0, 99) < 45);
            x = ($urandom_range(0, 99) < 35);
            apply(e, x);
            check_all($sformatf("rnd%0d", i), m_cnt);
        end

        // make sure the count is nonzero before the asynchronous reset
        apply(0, 0);
        apply(1, 0);
        apply(0, 0);
        apply(1, 0);
        cmp("pre-async nonzero", (bus.Parking_count != 0) ? 1 : 0, 1);

        // reset asserted between edges must clear outputs at once
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        model_reset();
        check_all("async reset", 0);

        // entry held high across reset release counts on the first edge
        bus.ENTRY_sensor = 1'b1;
        bus.EXIT_sensor  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset hold", 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        model_step(1, 0);
        check_all("release edge", 1);
        apply(1, 0);
        check_all("release hold", 1);
        apply(0, 0);
        check_all("release low", m_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_parking_management_system
